// File: rtl/gf2_syndrome_decoder_if.sv
// Receive/result handshake bundle for gf2_syndrome_decoder; out_synd exists only with GF2_DEC_SYND_OUT_EN.
interface gf2_syndrome_decoder_if #(
  parameter int CODE_LEN = 8,
  parameter int SYND_LEN = 4
);
  localparam int POS_W = $clog2(CODE_LEN);

  logic [SYND_LEN*CODE_LEN-1:0] H_data_in;
  logic [CODE_LEN-1:0]          in_word;
  logic                         in_valid;
  logic                         in_ready;
  logic [CODE_LEN-1:0]          out_word;
  logic [1:0]                   out_err;
  logic [POS_W-1:0]             out_pos;
  logic                         out_valid;
  logic                         out_ready;
`ifdef GF2_DEC_SYND_OUT_EN
  logic [SYND_LEN-1:0]          out_synd;

  modport master (
    output H_data_in, in_word, in_valid, out_ready,
    input  in_ready, out_word, out_err, out_pos, out_valid, out_synd
  );
  modport slave (
    input  H_data_in, in_word, in_valid, out_ready,
    output in_ready, out_word, out_err, out_pos, out_valid, out_synd
  );
`else
  modport master (
    output H_data_in, in_word, in_valid, out_ready,
    input  in_ready, out_word, out_err, out_pos, out_valid
  );
  modport slave (
    input  H_data_in, in_word, in_valid, out_ready,
    output in_ready, out_word, out_err, out_pos, out_valid
  );
`endif
endinterface

// File: rtl/gf2_syndrome_decoder.sv
// GF(2) syndrome decoder: s=H*r one column/cycle, then single-bit correction search; CODE_LEN..2*CODE_LEN cycles.
// Result held in DONE until out_ready; accepts only when idle. GF2_DEC_SYND_OUT_EN exposes the final syndrome.
module gf2_syndrome_decoder #(
  parameter int CODE_LEN = 8,
  parameter int SYND_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  gf2_syndrome_decoder_if.slave bus
);
  localparam int POS_W = $clog2(CODE_LEN);

  typedef enum logic [1:0] {IDLE, SYND, SRCH, DONE} state_t;

  state_t                       state_q, state_d;
  logic [POS_W-1:0]             col_q;
  logic [SYND_LEN-1:0]          synd_q;
  logic [CODE_LEN-1:0]          word_q;
  logic [SYND_LEN*CODE_LEN-1:0] h_q;
  logic [1:0]                   err_q;
  logic [POS_W-1:0]             pos_q;
  logic                         in_ready_q;

  logic [SYND_LEN-1:0]          hcol;
  logic [SYND_LEN-1:0]          synd_acc;
  logic                         last_col;
  logic                         col_match;
  logic                         accept;

  always_comb begin
    hcol = '0;
    for (int r = 0; r < SYND_LEN; r++) begin
      hcol[r] = h_q[CODE_LEN*r + int'(col_q)];
    end
  end

  assign synd_acc  = synd_q ^ (hcol & {SYND_LEN{word_q[col_q]}});
  assign last_col  = (col_q == POS_W'(CODE_LEN-1));
  assign col_match = (hcol == synd_q);
  assign accept    = bus.in_valid && in_ready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = SYND;
      SYND: if (last_col) state_d = (synd_acc == '0) ? DONE : SRCH;
      SRCH: if (col_match || last_col) state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q      <= '0;
      synd_q     <= '0;
      word_q     <= '0;
      h_q        <= '0;
      err_q      <= 2'b00;
      pos_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      // in_ready is registered so it stays low through reset and rises one cycle after the DONE handshake.
      in_ready_q <= (state_d == IDLE);
      case (state_q)
        IDLE: if (accept) begin
          word_q <= bus.in_word;
          h_q    <= bus.H_data_in;
          synd_q <= '0;
          col_q  <= '0;
          err_q  <= 2'b00;
          pos_q  <= '0;
        end
        SYND: begin
          synd_q <= synd_acc;
          col_q  <= last_col ? '0 : col_q + 1'b1;
        end
        SRCH: begin
          if (col_match) begin
            word_q[col_q] <= ~word_q[col_q];
            pos_q         <= col_q;
            err_q         <= 2'b01;
          end else if (last_col) begin
            err_q <= 2'b10;
            pos_q <= '0;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.out_valid = (state_q == DONE);
    bus.in_ready  = in_ready_q;
    bus.out_word  = word_q;
    bus.out_err   = err_q;
    bus.out_pos   = pos_q;
`ifdef GF2_DEC_SYND_OUT_EN
    bus.out_synd  = synd_q;
`endif
  end
endmodule

// File: doc/gf2_syndrome_decoder.md
Name: gf2_syndrome_decoder

Overview:
- Receiving-side counterpart of the GF(2) matrix-vector encoder. Takes a received codeword r and a parity-check matrix H, and computes the syndrome s = H·r over GF(2), one column per cycle.
- If s is nonzero, it searches H for a column equal to s, flips the matching bit, and returns the corrected word with an error status.
- Sits between the channel/receive buffer and the data consumer, with valid/ready handshakes on both sides.

Parameters:
- CODE_LEN, 8, codeword length; number of H columns.
- SYND_LEN, 4, syndrome width; number of H rows.
- POS_W, $clog2(CODE_LEN), width of the error-position index (localparam).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- H_data_in  input  SYND_LEN*CODE_LEN  parity-check matrix, row-major: H[r][c] = H_data_in[CODE_LEN*r + c].
- in_word  input  CODE_LEN  received codeword; bit c pairs with H column c.
- in_valid  input  1  in_word/H_data_in valid.
- in_ready  output  1  decoder idle, can accept.
- out_word  output  CODE_LEN  corrected codeword.
- out_err  output  2  00 clean, 01 corrected, 10 uncorrectable, 11 never driven.
- out_pos  output  POS_W  index of flipped bit; 0 unless out_err=01.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.

Behaviour:
- Reset (rst=0, async): state IDLE. Column counter, syndrome, word and H registers cleared. out_word=0, out_err=00, out_pos=0, out_valid=0, in_ready=0 while rst=0. in_ready=1 in the first cycle after reset release.
- States: IDLE, SYND, SRCH, DONE. All outputs are registered or decoded from state only; no input-to-output combinational path.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge E0: latch in_word and H_data_in, clear syndrome, col=0, go to SYND.
- SYND: each cycle, s <= s ^ (H column col AND replicate(word[col])), col++.
  - On the edge processing col=CODE_LEN-1, evaluate the final syndrome including that column.
  - Zero syndrome: go to DONE with err=00.
  - Nonzero syndrome: go to SRCH with col=0.
- SRCH: each cycle, compare H column col with s.
  - Match: flip word[col], pos=col, err=01, go to DONE. Lowest matching index wins if H has duplicate columns.
  - No match at col=CODE_LEN-1: err=10, word unchanged, pos=0, go to DONE.
  - An all-zero column never matches, since s≠0 here.
- DONE: out_valid=1 and outputs stable. On out_valid&out_ready, go to IDLE. in_ready rises the following cycle; there is no same-cycle re-accept.
- Latency from accept edge E0 to out_valid high:
  - Clean: CODE_LEN cycles.
  - Corrected at column k: CODE_LEN+k+1 cycles.
  - Uncorrectable: 2*CODE_LEN cycles.
- Inputs are ignored outside IDLE. H_data_in and in_word may change after acceptance without effect.
- out_ready held high: out_valid is a one-cycle pulse. out_ready low: outputs hold indefinitely.
- Reset mid-operation: result discarded, all outputs and state return to reset values immediately.

Optional Feature:
- Macro GF2_DEC_SYND_OUT_EN.
- Defined: adds output port out_synd [SYND_LEN-1:0] carrying the final syndrome. It is registered and valid with out_valid, 0 at reset, and holds while in DONE.
- Undefined: the port does not exist and the syndrome register is internal only. All other behaviour is identical.

Test Plan (CODE_LEN=8, SYND_LEN=4, H column c = c+1 in binary, row 0 = LSB):
- in_word=0x00, out_ready=1 -> out_word=0x00, out_err=00, out_pos=0; out_valid exactly 8 cycles after accept, for 1 cycle.
- in_word=0x20 (syndrome 6) -> out_word=0x00, out_err=01, out_pos=5; out_valid 14 cycles after accept.
- in_word=0x81 (syndrome 9, no matching column) -> out_word=0x81, out_err=10, out_pos=0; out_valid 16 cycles after accept.
- in_word=0x01, out_ready=0 for 5 cycles in DONE -> out_word=0x00, out_err=01, out_pos=0, all held stable; in_valid pulses during the hold are ignored. in_ready=1 one cycle after out_ready=1 handshake.
- Accept 0x20, assert rst=0 in cycle 4 of SYND -> out_valid=0 and outputs 0 immediately. After release, a fresh 0x00 decodes clean in 8 cycles.
- With GF2_DEC_SYND_OUT_EN defined: in_word=0x20 -> out_synd=4'h6; in_word=0x00 -> out_synd=4'h0.
